regfile_wr_arbiter: RTL

//  Shares the single regfile write port (wb_wreg/wb_waddr/wb_wdata) between the pipeline WB stage and an

---
 rtl/regfile_wr_arbiter_pkg.sv | 28 ++
 rtl/regfile_wr_arbiter_if.sv | 30 +++
 rtl/regfile_wr_fifo.sv | 57 +++++
 rtl/regfile_wr_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter slice.
package regfile_wr_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_data_t;

    localparam logic      RST_ENABLE   = 1'b1;
    localparam logic      WRITE_ENABLE = 1'b1;
    localparam logic      STALL_REQ    = 1'b1;
    localparam logic      NO_STALL_REQ = 1'b0;
    localparam reg_addr_t NOP_REG_ADDR = '0;
    localparam reg_data_t ZERO_WORD    = '0;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } aux_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Pipeline, aux-requester and regfile-side signals of the write-port arbiter.
interface regfile_wr_arbiter_if;
    import regfile_wr_arbiter_pkg::*;

    logic      pipe_wreg_i;
    reg_addr_t pipe_waddr_i;
    reg_data_t pipe_wdata_i;
    logic      aux_req_i;
    reg_addr_t aux_waddr_i;
    reg_data_t aux_wdata_i;
    logic      aux_gnt_o;
    logic      wb_wreg_o;
    reg_addr_t wb_waddr_o;
    reg_data_t wb_wdata_o;
    logic      stall_req_o;
    logic      busy_o;

    modport master (
        output pipe_wreg_i, pipe_waddr_i, pipe_wdata_i,
        output aux_req_i, aux_waddr_i, aux_wdata_i,
        input  aux_gnt_o, wb_wreg_o, wb_waddr_o, wb_wdata_o, stall_req_o, busy_o
    );

    modport slave (
        input  pipe_wreg_i, pipe_waddr_i, pipe_wdata_i,
        input  aux_req_i, aux_waddr_i, aux_wdata_i,
        output aux_gnt_o, wb_wreg_o, wb_waddr_o, wb_wdata_o, stall_req_o, busy_o
    );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Small FIFO of pending aux register writes; head is shown combinationally.
module regfile_wr_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  aux_entry_t               push_entry,
    output aux_entry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    aux_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers/count alone define validity, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between the WB stage (always wins) and a queued aux requester,
// with a starvation guard that asks the pipeline for bubbles.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wr_arbiter_if.slave bus
);

    localparam int                CNT_W    = $clog2(STARVE_LIM) + 1;
    localparam logic [CNT_W-1:0]  WAIT_MAX = CNT_W'(STARVE_LIM - 1);
    localparam int                OCC_W    = $clog2(DEPTH) + 1;

    arb_state_t       state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_n;
    aux_entry_t       head;
    logic             full, empty;
    logic [OCC_W-1:0] count;
    logic             in_reset, push, pop, blocked, last_pop;

    assign in_reset = (rst == RST_ENABLE);
    // Full is judged before any same-cycle pop, so a full FIFO never grants.
    assign bus.aux_gnt_o = !full && !in_reset;
    assign push     = bus.aux_req_i && bus.aux_gnt_o && (bus.aux_waddr_i != NOP_REG_ADDR);
    assign pop      = !in_reset && (bus.pipe_wreg_i != WRITE_ENABLE) && !empty;
    assign blocked  = !empty && (bus.pipe_wreg_i == WRITE_ENABLE);
    assign last_pop = pop && !push && (count == OCC_W'(1));
    assign bus.busy_o = (count != '0);

    regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_entry ('{addr: bus.aux_waddr_i, data: bus.aux_wdata_i}),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        bus.wb_wreg_o  = 1'b0;
        bus.wb_waddr_o = NOP_REG_ADDR;
        bus.wb_wdata_o = ZERO_WORD;
        if (in_reset) begin
            bus.wb_wreg_o = 1'b0;
        end else if (bus.pipe_wreg_i == WRITE_ENABLE) begin
            bus.wb_wreg_o  = 1'b1;
            bus.wb_waddr_o = bus.pipe_waddr_i;
            bus.wb_wdata_o = bus.pipe_wdata_i;
        end else if (!empty) begin
            bus.wb_wreg_o  = 1'b1;
            bus.wb_waddr_o = head.addr;
            bus.wb_wdata_o = head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
        end
    end

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        case (state)
            ST_IDLE: begin
                wait_n = '0;
                if (push) state_n = ST_PEND;
            end
            ST_PEND: begin
                if (pop) begin
                    wait_n = '0;
                    if (last_pop) state_n = ST_IDLE;
                end else if (blocked) begin
                    if (wait_cnt == WAIT_MAX) state_n = ST_FORCE;
                    else                      wait_n  = wait_cnt + CNT_W'(1);
                end
            end
            ST_FORCE: begin
                if (pop) begin
                    wait_n  = '0;
                    state_n = last_pop ? ST_IDLE : ST_PEND;
                end
            end
            default: begin
                state_n = ST_IDLE;
                wait_n  = '0;
            end
        endcase
    end

    // The stall request is the registered FORCE state, released in the very cycle the head drains.
    assign bus.stall_req_o = (state == ST_FORCE && !pop) ? STALL_REQ : NO_STALL_REQ;

endmodule
